// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

    localparam int WORD_W = 16;

    localparam logic [WORD_W-1:0] NOP_INSTR_DEFAULT = 16'h0800;
    localparam logic [WORD_W-1:0] RESET_PC_DEFAULT  = 16'h0000;

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        VALID,
        HALTED
    } fetch_state_t;

endpackage

// File: rtl/cla_add16.sv
// 16-bit carry-lookahead adder: four 4-bit lookahead groups plus a group-level lookahead.
module cla_add16
    import fetch_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    output logic [WORD_W-1:0] sum
);

    logic [14:0] g;
    logic [15:0] p;
    logic [2:0]  gg;
    logic [2:0]  gp;
    logic [3:0]  cg;

    assign g = a[14:0] & b[14:0];
    assign p = a ^ b;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_group_gp
            assign gg[gi] = g[4*gi+3]
                          | (p[4*gi+3] & g[4*gi+2])
                          | (p[4*gi+3] & p[4*gi+2] & g[4*gi+1])
                          | (p[4*gi+3] & p[4*gi+2] & p[4*gi+1] & g[4*gi]);
            assign gp[gi] = &p[4*gi +: 4];
        end
    endgenerate

    // Carry into each group, flattened so no carry depends on another carry bit.
    assign cg[0] = 1'b0;
    assign cg[1] = gg[0];
    assign cg[2] = gg[1] | (gp[1] & gg[0]);
    assign cg[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]);

    generate
        for (gi = 0; gi < 4; gi++) begin : g_group_sum
            logic       ci;
            logic [3:0] c;
            assign ci   = cg[gi];
            assign c[0] = ci;
            assign c[1] = g[4*gi] | (p[4*gi] & ci);
            assign c[2] = g[4*gi+1] | (p[4*gi+1] & g[4*gi]) | (p[4*gi+1] & p[4*gi] & ci);
            assign c[3] = g[4*gi+2]
                        | (p[4*gi+2] & g[4*gi+1])
                        | (p[4*gi+2] & p[4*gi+1] & g[4*gi])
                        | (p[4*gi+2] & p[4*gi+1] & p[4*gi] & ci);
            assign sum[4*gi +: 4] = p[4*gi +: 4] ^ c;
        end
    endgenerate

endmodule

// File: rtl/sat_cnt16.sv
// 16-bit event counter with enable that sticks at all-ones instead of wrapping.
module sat_cnt16
    import fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic [WORD_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (en && (cnt != {WORD_W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, drives a request/done instruction memory, presents valid/ready to decode.
// Optional performance counters are built only when FETCH_CTRL_PERF_EN is defined.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [WORD_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic [WORD_W-1:0] mem_addr,
    input  logic              mem_done,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              redirect_valid,
    input  logic [WORD_W-1:0] redirect_pc,
    input  logic              if_ready,
    input  logic              halt_in,
    output logic              if_valid,
    output logic [WORD_W-1:0] if_instr,
    output logic [WORD_W-1:0] if_pc,
    output logic [WORD_W-1:0] if_pc_plus2,
    output logic              halted
`ifdef FETCH_CTRL_PERF_EN
    ,
    output logic [WORD_W-1:0] perf_fetch_cnt,
    output logic [WORD_W-1:0] perf_squash_cnt
`endif
);

    fetch_state_t      state_reg, state_next;
    logic [WORD_W-1:0] pc_reg, pc_next;
    logic              squash_reg, squash_next;
    logic              valid_reg, valid_next;
    logic [WORD_W-1:0] instr_reg, instr_next;
    logic [WORD_W-1:0] out_pc_reg, out_pc_next;
    logic              halted_reg, halted_next;
    logic [WORD_W-1:0] pc_plus2;
    logic [WORD_W-1:0] redirect_target;

    assign redirect_target = redirect_pc & {{(WORD_W-1){1'b1}}, 1'b0};

    cla_add16 u_pc_inc (
        .a   (pc_reg),
        .b   (WORD_W'(2)),
        .sum (pc_plus2)
    );

    cla_add16 u_out_pc_inc (
        .a   (out_pc_reg),
        .b   (WORD_W'(2)),
        .sum (if_pc_plus2)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= REQ;
            pc_reg     <= RESET_PC;
            squash_reg <= 1'b0;
            valid_reg  <= 1'b0;
            instr_reg  <= NOP_INSTR;
            out_pc_reg <= RESET_PC;
            halted_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            pc_reg     <= pc_next;
            squash_reg <= squash_next;
            valid_reg  <= valid_next;
            instr_reg  <= instr_next;
            out_pc_reg <= out_pc_next;
            halted_reg <= halted_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        pc_next     = pc_reg;
        squash_next = squash_reg;
        valid_next  = valid_reg;
        instr_next  = instr_reg;
        out_pc_next = out_pc_reg;
        halted_next = halted_reg;
        mem_req     = 1'b0;
        mem_addr    = pc_reg;

        case (state_reg)
            REQ: begin
                if (redirect_valid) begin
                    pc_next = redirect_target;
                end else begin
                    // State resets to REQ, so the request must be held off while reset is asserted.
                    mem_req    = rst_n;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (mem_done) begin
                    if (squash_reg || redirect_valid) begin
                        squash_next = 1'b0;
                        state_next  = REQ;
                        if (redirect_valid) begin
                            pc_next = redirect_target;
                        end
                    end else begin
                        valid_next  = 1'b1;
                        instr_next  = mem_rdata;
                        out_pc_next = pc_reg;
                        pc_next     = pc_plus2;
                        state_next  = VALID;
                    end
                end else if (redirect_valid) begin
                    pc_next     = redirect_target;
                    squash_next = 1'b1;
                end
            end
            VALID: begin
                if (redirect_valid) begin
                    valid_next = 1'b0;
                    instr_next = NOP_INSTR;
                    pc_next    = redirect_target;
                    state_next = REQ;
                end else if (if_ready) begin
                    valid_next = 1'b0;
                    instr_next = NOP_INSTR;
                    if (halt_in) begin
                        halted_next = 1'b1;
                        state_next  = HALTED;
                    end else begin
                        mem_req    = 1'b1;
                        state_next = WAIT;
                    end
                end
            end
            HALTED: begin
            end
            default: begin
                state_next = REQ;
            end
        endcase
    end

    assign if_valid = valid_reg;
    assign if_instr = instr_reg;
    assign if_pc    = out_pc_reg;
    assign halted   = halted_reg;

`ifdef FETCH_CTRL_PERF_EN
    logic fetch_evt;
    logic squash_evt;

    assign fetch_evt  = (state_reg == VALID) && !redirect_valid && if_ready;
    // Discarded responses in WAIT plus valid instructions dropped by a redirect.
    assign squash_evt = ((state_reg == WAIT) && mem_done && (squash_reg || redirect_valid))
                      || ((state_reg == VALID) && redirect_valid);

    sat_cnt16 u_fetch_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (fetch_evt),
        .cnt   (perf_fetch_cnt)
    );

    sat_cnt16 u_squash_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (squash_evt),
        .cnt   (perf_squash_cnt)
    );
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus random traffic checked against an instruction-stream model.
module tb_fetch_ctrl;

    localparam logic [15:0] NOP = 16'h0800;
    localparam logic [15:0] RPC = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_done;
    logic [15:0] mem_rdata;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = 16'h0;
    logic        if_ready = 1'b0;
    logic        halt_in = 1'b0;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic [15:0] if_pc_plus2;
    logic        halted;
`ifdef FETCH_CTRL_PERF_EN
    logic [15:0] pf;
    logic [15:0] ps;
`endif

    fetch_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_done       (mem_done),
        .mem_rdata      (mem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_ready       (if_ready),
        .halt_in        (halt_in),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_pc_plus2    (if_pc_plus2),
        .halted         (halted)
`ifdef FETCH_CTRL_PERF_EN
        ,
        .perf_fetch_cnt  (pf),
        .perf_squash_cnt (ps)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        logic [15:0] m;
        m = a * 16'h9E37;
        return m ^ 16'h3C5A;
    endfunction

    function automatic logic [15:0] inc2(input logic [15:0] a);
        return a + 16'd2;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_vec++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    // Memory: fixed content per address, one outstanding request, latency mem_lat cycles.
    int          mem_lat = 1;
    logic        busy;
    int          cnt;
    logic [15:0] req_addr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_done  <= 1'b0;
            mem_rdata <= 16'hDEAD;
            busy      <= 1'b0;
            cnt       <= 0;
            req_addr  <= 16'h0;
        end else begin
            mem_done  <= 1'b0;
            mem_rdata <= 16'hDEAD;
            if (busy) begin
                if (cnt == 1) begin
                    mem_done  <= 1'b1;
                    mem_rdata <= mem_word(req_addr);
                    busy      <= 1'b0;
                end else begin
                    cnt <= cnt - 1;
                end
            end
            if (mem_req) begin
                req_addr <= mem_addr;
                if (mem_lat == 1) begin
                    mem_done  <= 1'b1;
                    mem_rdata <= mem_word(mem_addr);
                end else begin
                    busy <= 1'b1;
                    cnt  <= mem_lat - 1;
                end
            end
        end
    end

    // Stream model: which PC decode must see next, plus stall/halt bookkeeping.
    logic [15:0] exp_pc = RPC;
    logic        halted_exp = 1'b0;
    logic        stall_prev = 1'b0;
    logic [15:0] stall_instr, stall_pc;
    int          idle = 0;
    int          acc_cnt = 0;

    logic        s_req, s_valid, s_halted;
    logic [15:0] s_addr, s_instr, s_pc, s_p2;

    task automatic model_check(input logic rv, input logic [15:0] rpc, input logic rdy, input logic hlt);
        if (!rst_n) begin
            chk("rst_req", s_req, 0);
            chk("rst_valid", s_valid, 0);
            chk("rst_instr", s_instr, NOP);
            chk("rst_pc", s_pc, RPC);
            chk("rst_pc2", s_p2, inc2(RPC));
            chk("rst_halted", s_halted, 0);
            exp_pc = RPC; halted_exp = 1'b0; stall_prev = 1'b0; idle = 0; acc_cnt = 0;
            return;
        end
        chk("halted", s_halted, halted_exp);
        if (halted_exp) begin
            chk("halt_req", s_req, 0);
            chk("halt_valid", s_valid, 0);
        end
        if (!s_valid) begin
            chk("nop_instr", s_instr, NOP);
        end else begin
            chk("if_pc", s_pc, exp_pc);
            chk("if_instr", s_instr, mem_word(s_pc));
            chk("if_pc_plus2", s_p2, inc2(s_pc));
        end
        if (stall_prev) begin
            chk("stall_valid", s_valid, 1);
            chk("stall_instr", s_instr, stall_instr);
            chk("stall_pc", s_pc, stall_pc);
        end
        if (s_valid) begin
            if (rdy && !rv && !hlt) begin
                chk("accept_req", s_req, 1);
                chk("accept_addr", s_addr, inc2(s_pc));
            end else begin
                chk("hold_req", s_req, 0);
            end
        end else if (rv) begin
            chk("redirect_req", s_req, 0);
        end else if (s_req) begin
            chk("req_addr", s_addr, exp_pc);
        end
        if (busy || mem_done) chk("overlap_req", s_req, 0);
        if (s_valid || halted_exp) idle = 0; else idle++;
        if (idle == 81) chk("liveness", idle, 0);

        stall_prev = 1'b0;
        if (!halted_exp) begin
            if (rv) begin
                exp_pc = rpc & 16'hFFFE;
            end else if (s_valid && rdy) begin
                acc_cnt++;
                if (hlt) halted_exp = 1'b1;
                else exp_pc = inc2(s_pc);
            end else if (s_valid) begin
                stall_prev = 1'b1;
                stall_instr = s_instr;
                stall_pc = s_pc;
            end
        end
    endtask

    task automatic tick(input logic rv, input logic [15:0] rpc, input logic rdy, input logic hlt);
        redirect_valid = rv; redirect_pc = rpc; if_ready = rdy; halt_in = hlt;
        @(negedge clk);
        s_req = mem_req; s_addr = mem_addr; s_valid = if_valid; s_instr = if_instr;
        s_pc = if_pc; s_p2 = if_pc_plus2; s_halted = halted;
        model_check(rv, rpc, rdy, hlt);
        @(posedge clk); #1;
    endtask

    task automatic wait_valid(input logic rdy);
        int n;
        n = 0;
        tick(1'b0, 16'h0, rdy, 1'b0);
        while (!s_valid && n < 30) begin
            tick(1'b0, 16'h0, rdy, 1'b0);
            n++;
        end
        if (!s_valid) chk("wait_valid_timeout", s_valid, 1);
    endtask

    initial begin
        int nvalid, nreq, n;
        logic [15:0] pc_hold;
`ifdef FETCH_CTRL_PERF_EN
        logic [15:0] sq0;
`endif
        @(posedge clk); #1;
        tick(1'b0, 16'h0, 1'b1, 1'b0);
        tick(1'b0, 16'h0, 1'b1, 1'b0);

        // Reset release with single-cycle memory
        mem_lat = 1;
        rst_n = 1'b1;
        tick(1'b0, 16'h0, 1'b1, 1'b0);
        chk("c1_req", s_req, 1);
        chk("c1_addr", s_addr, 16'h0000);
        tick(1'b0, 16'h0, 1'b1, 1'b0);
        chk("c2_valid", s_valid, 0);
        tick(1'b0, 16'h0, 1'b1, 1'b0);
        chk("c3_valid", s_valid, 1);
        chk("c3_pc", s_pc, 16'h0000);
        chk("c3_req", s_req, 1);
        chk("c3_addr", s_addr, 16'h0002);

        // Four-cycle decode stall, then the request for pc+2 when ready rises
        wait_valid(1'b0);
        for (int i = 0; i < 3; i++) tick(1'b0, 16'h0, 1'b0, 1'b0);
        pc_hold = s_pc;
        mem_lat = 4;
        tick(1'b0, 16'h0, 1'b1, 1'b0);
        chk("stall_release_req", s_req, 1);
        chk("stall_release_addr", s_addr, inc2(pc_hold));

        // Redirect during WAIT: response drained and discarded
`ifdef FETCH_CTRL_PERF_EN
        sq0 = ps;
`endif
        tick(1'b1, 16'h0041, 1'b1, 1'b0);
        nvalid = 0; n = 0;
        tick(1'b0, 16'h0, 1'b1, 1'b0);
        while (!s_req && n < 20) begin
            if (s_valid) nvalid++;
            tick(1'b0, 16'h0, 1'b1, 1'b0);
            n++;
        end
        chk("squash_req_seen", s_req, 1);
        chk("squash_addr", s_addr, 16'h0040);
        chk("squash_no_valid", nvalid, 0);
`ifdef FETCH_CTRL_PERF_EN
        chk("perf_squash_delta", ps - sq0, 1);
`endif

        // Redirect together with ready in VALID: redirect wins
        mem_lat = 2;
        wait_valid(1'b0);
        tick(1'b1, 16'h1234, 1'b1, 1'b0);
        chk("redir_valid_noreq", s_req, 0);
        tick(1'b0, 16'h0, 1'b0, 1'b0);
        chk("redir_valid_dropped", s_valid, 0);
        chk("redir_target_req", s_req, 1);
        chk("redir_target_addr", s_addr, 16'h1234);

        // PC wrap at 0xFFFE
        wait_valid(1'b0);
        tick(1'b1, 16'hFFFF, 1'b0, 1'b0);
        wait_valid(1'b0);
        chk("wrap_pc", s_pc, 16'hFFFE);
        chk("wrap_pc_plus2", s_p2, 16'h0000);
        tick(1'b0, 16'h0, 1'b1, 1'b0);
        chk("wrap_req", s_req, 1);
        chk("wrap_addr", s_addr, 16'h0000);

        // Random traffic against the stream model
        for (int i = 0; i < 400; i++) begin
            logic rv, rdy;
            logic [15:0] rpc;
            if ($urandom_range(3, 0) == 0) mem_lat = $urandom_range(4, 1);
            rv  = ($urandom_range(15, 0) == 0);
            rpc = 16'($urandom);
            rdy = ($urandom_range(9, 0) < 7);
            tick(rv, rpc, rdy, 1'b0);
        end
`ifdef FETCH_CTRL_PERF_EN
        chk("perf_fetch", pf, acc_cnt);
`endif

        // HALT with the handshake, then only reset restarts fetch
        wait_valid(1'b0);
        tick(1'b0, 16'h0, 1'b1, 1'b1);
        tick(1'b0, 16'h0, 1'b0, 1'b0);
        chk("halt_flag", s_halted, 1);
        nreq = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1'($urandom_range(1, 0)), 16'($urandom), 1'($urandom_range(1, 0)), 1'b0);
            if (s_req) nreq++;
        end
        chk("halt_no_req", nreq, 0);
        rst_n = 1'b0;
        tick(1'b0, 16'h0, 1'b1, 1'b0);
        rst_n = 1'b1;
        tick(1'b0, 16'h0, 1'b1, 1'b0);
        chk("restart_req", s_req, 1);
        chk("restart_addr", s_addr, 16'h0000);
        chk("restart_halted", s_halted, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
